// File: rtl/ballot_result_reader_if.sv
// Valid/ready stream carrying one (candidate ID, vote count) entry per handshake.
// The read-out block is the master; the display/report path is the slave.
interface ballot_result_reader_if #(
   parameter int unsigned CAND_W  = 4,
   parameter int unsigned COUNT_W = 4
);
   logic               out_valid;
   logic               out_ready;
   logic [CAND_W-1:0]  out_candidate;
   logic [COUNT_W-1:0] out_count;

   modport master (
      output out_valid,
      output out_candidate,
      output out_count,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_candidate,
      input  out_count,
      output out_ready
   );
endinterface

// File: rtl/ballot_result_reader.sv
// Snapshots all ballot memory units on start, streams them out one entry per handshake,
// and tracks the highest count plus a tie flag, published when the read-out finishes.
module ballot_result_reader #(
   parameter int unsigned NUM_CAND = 4,
   parameter int unsigned CAND_W   = 4,
   parameter int unsigned COUNT_W  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_i,
   input  logic [NUM_CAND*CAND_W-1:0]  cand_ids_i,
   input  logic [NUM_CAND*COUNT_W-1:0] vote_counts_i,
   ballot_result_reader_if.master      out_if,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [CAND_W-1:0]           winner_id_o,
   output logic [COUNT_W-1:0]          winner_count_o,
   output logic                        tie_o
);

   localparam int unsigned     IdxW    = $clog2(NUM_CAND);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CAND - 1);

   typedef enum logic [1:0] {StIdle, StSend, StFin} state_e;

   state_e             state_q;
   logic [IdxW-1:0]    idx_q;
   logic [IdxW-1:0]    idx_nxt;
   logic [CAND_W-1:0]  ids_q  [NUM_CAND];
   logic [COUNT_W-1:0] cnts_q [NUM_CAND];
   logic [CAND_W-1:0]  max_id_q;
   logic [COUNT_W-1:0] max_cnt_q;
   logic               max_tie_q;
   logic               valid_q;
   logic               done_q;
   logic [CAND_W-1:0]  cand_q;
   logic [COUNT_W-1:0] count_q;
   logic [CAND_W-1:0]  win_id_q;
   logic [COUNT_W-1:0] win_cnt_q;
   logic               tie_q;

   assign idx_nxt = idx_q + IdxW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         for (int unsigned i = 0; i < NUM_CAND; i++) begin
            ids_q[i]  <= '0;
            cnts_q[i] <= '0;
         end
         max_id_q  <= '0;
         max_cnt_q <= '0;
         max_tie_q <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         cand_q    <= '0;
         count_q   <= '0;
         win_id_q  <= '0;
         win_cnt_q <= '0;
         tie_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  for (int unsigned i = 0; i < NUM_CAND; i++) begin
                     ids_q[i]  <= cand_ids_i[i*CAND_W +: CAND_W];
                     cnts_q[i] <= vote_counts_i[i*COUNT_W +: COUNT_W];
                  end
                  idx_q     <= '0;
                  max_id_q  <= '0;
                  max_cnt_q <= '0;
                  max_tie_q <= 1'b0;
                  valid_q   <= 1'b1;
                  // Entry 0 comes straight from the bus so it is valid next cycle.
                  cand_q    <= cand_ids_i[CAND_W-1:0];
                  count_q   <= vote_counts_i[COUNT_W-1:0];
                  state_q   <= StSend;
               end
            end
            StSend: begin
               if (out_if.out_ready) begin
                  // Strict > keeps the lower-index ID on equal counts.
                  if (idx_q == '0 || count_q > max_cnt_q) begin
                     max_id_q  <= cand_q;
                     max_cnt_q <= count_q;
                     max_tie_q <= 1'b0;
                  end else if (count_q == max_cnt_q) begin
                     max_tie_q <= 1'b1;
                  end
                  if (idx_q == LastIdx) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     idx_q   <= idx_nxt;
                     cand_q  <= ids_q[idx_nxt];
                     count_q <= cnts_q[idx_nxt];
                  end
               end
            end
            StFin: begin
               win_id_q  <= max_id_q;
               win_cnt_q <= max_cnt_q;
               tie_q     <= max_tie_q;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_if.out_valid     = valid_q;
   assign out_if.out_candidate = cand_q;
   assign out_if.out_count     = count_q;
   assign busy_o               = (state_q != StIdle);
   assign done_o               = done_q;
   assign winner_id_o          = win_id_q;
   assign winner_count_o       = win_cnt_q;
   assign tie_o                = tie_q;

endmodule
